// File: rtl/data_mem_bridge.sv
// data_mem_bridge: zero-latency data RAM with byte enables plus a memory-mapped countdown timer
module data_mem_bridge #(
    parameter int          DM_WORDS   = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h00007F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] DM_PC,
    input  logic [31:0] DM_Addr,
    input  logic [31:0] DM_WData,
    input  logic [3:0]  DM_WE,
    output logic [31:0] DM_RData,
    output logic        irq
);
    localparam int AW = $clog2(DM_WORDS);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t state, state_n;
    logic [31:0] ram [DM_WORDS];
    logic [3:0]  ctrl;
    logic [31:0] preset, count;
    logic        irq_flag;
    logic [AW-1:0] idx;
    logic ram_sel, ctrl_sel, preset_sel, count_sel, full_wr, ctrl_wr, preset_wr, mode1, load, dec;
    logic unused_pc;
    assign unused_pc  = ^DM_PC;
    assign idx        = DM_Addr[AW+1:2];
    assign ram_sel    = DM_Addr < 32'(4 * DM_WORDS);
    assign ctrl_sel   = DM_Addr == TIMER_BASE;
    assign preset_sel = DM_Addr == TIMER_BASE + 32'd4;
    assign count_sel  = DM_Addr == TIMER_BASE + 32'd8;
    assign full_wr    = DM_WE == 4'b1111;
    assign ctrl_wr    = full_wr && ctrl_sel;
    assign preset_wr  = full_wr && preset_sel;
    assign mode1      = ctrl[2:1] == 2'b01;
    assign DM_RData   = ram_sel ? ram[idx] : ctrl_sel ? {28'b0, ctrl} : preset_sel ? preset : count_sel ? count : 32'h0;
    assign irq        = ctrl[3] & irq_flag;
    // RAM: cleared on reset, otherwise only enabled byte lanes of a mapped word are written
    always_ff @(posedge clk)
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) ram[i] <= '0;
        end else if (ram_sel) begin
            for (int i = 0; i < 4; i++) if (DM_WE[i]) ram[idx][8*i +: 8] <= DM_WData[8*i +: 8];
        end
    // timer FSM state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    // timer FSM next state; load copies PRESET, dec steps COUNT towards zero
    always_comb begin
        state_n = state;
        load    = 1'b0;
        dec     = 1'b0;
        case (state)
            IDLE: state_n = ctrl[0] ? LOAD : IDLE;
            LOAD: begin
                state_n = CNT;
                load    = 1'b1;
            end
            CNT: begin
                state_n = !ctrl[0] ? IDLE : count <= 32'd1 ? INT : CNT;
                dec     = ctrl[0];
            end
            INT: state_n = mode1 ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end
    // timer registers; CPU writes take priority over FSM-driven updates
    always_ff @(posedge clk)
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= DM_WData[3:0];
            else if (state == INT && !mode1) ctrl[0] <= 1'b0;
            if (preset_wr) preset <= DM_WData;
            if (load) count <= preset;
            else if (dec) count <= count <= 32'd1 ? 32'd0 : count - 32'd1;
            if (ctrl_wr || preset_wr) irq_flag <= 1'b0;
            else if (state == INT) irq_flag <= 1'b1;
            else if (mode1) irq_flag <= 1'b0;
        end
endmodule
